// File: rtl/lx32_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : lx32_mem_pkg
//  Purpose  : Shared constants for the lx32 data-memory responder: default
//             MMIO page base, MMIO register byte offsets, the read value
//             returned for unmapped locations and STATUS bit positions.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package lx32_mem_pkg;

    // Default base of the 256-byte MMIO page (low 8 bits must be zero)
    localparam logic [31:0] DEFAULT_MMIO_BASE = 32'h8000_0000;

    // Returned for unmapped addresses and unused MMIO offsets
    localparam logic [31:0] DEAD_READ = 32'hDEAD_BEEF;

    // MMIO register byte offsets within the page
    localparam logic [7:0] MMIO_MTIME_LO    = 8'h00;
    localparam logic [7:0] MMIO_MTIME_HI    = 8'h04;
    localparam logic [7:0] MMIO_MTIMECMP_LO = 8'h08;
    localparam logic [7:0] MMIO_MTIMECMP_HI = 8'h0C;
    localparam logic [7:0] MMIO_TOHOST      = 8'h10;
    localparam logic [7:0] MMIO_STATUS      = 8'h14;

    // STATUS register bit positions
    localparam int STATUS_IRQ_BIT    = 0;
    localparam int STATUS_HALT_BIT   = 1;
    localparam int STATUS_BUSERR_BIT = 2;

endpackage : lx32_mem_pkg
`default_nettype wire

// File: rtl/lx32_data_mem_if.sv
`default_nettype none
// ============================================================================
//  Module   : lx32_data_mem_if
//  Purpose  : Core data-port bus between the lx32 core (master) and the
//             data-memory responder (slave).
//  Signals  : mem_addr  [31:0] byte address from core
//             mem_wdata [31:0] store data
//             mem_we           store strobe, sampled at posedge clk
//             mem_rdata [31:0] read data, combinational from mem_addr
//  Revision : 1.0 - initial release
// ============================================================================
interface lx32_data_mem_if;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic [31:0] mem_rdata;

    modport master (
        output mem_addr,
        output mem_wdata,
        output mem_we,
        input  mem_rdata
    );

    modport slave (
        input  mem_addr,
        input  mem_wdata,
        input  mem_we,
        output mem_rdata
    );
endinterface : lx32_data_mem_if
`default_nettype wire

// File: rtl/lx32_mtimer.sv
`default_nettype none
// ============================================================================
//  Module   : lx32_mtimer
//  Purpose  : Machine timer: free-running prescaler, 64-bit mtime, 64-bit
//             mtimecmp and the registered compare interrupt.
//  Ports    : clk, rst_n (async, active-low)
//             wdata[31:0]                 write data for any half
//             we_mtime_lo/hi              per-half mtime write strobes
//             we_mtimecmp_lo/hi           per-half mtimecmp write strobes
//             mtime[63:0], mtimecmp[63:0] current register values
//             irq                         registered (mtime >= mtimecmp)
//  Revision : 1.0 - initial release
// ============================================================================
module lx32_mtimer #(
    parameter int PRESCALE = 1
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    input  wire logic [31:0] wdata,
    input  wire logic        we_mtime_lo,
    input  wire logic        we_mtime_hi,
    input  wire logic        we_mtimecmp_lo,
    input  wire logic        we_mtimecmp_hi,
    output logic      [63:0] mtime,
    output logic      [63:0] mtimecmp,
    output logic             irq
);

    localparam int            PW         = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] c_PRE_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] r_pre;
    logic [63:0]   r_mtime;
    logic [63:0]   r_mtimecmp;
    logic          r_irq;
    logic          w_tick;

    // With PRESCALE=1 the counter sits at 0 == c_PRE_LAST, so it ticks every cycle
    assign w_tick = (r_pre == c_PRE_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pre      <= '0;
            r_mtime    <= '0;
            r_mtimecmp <= '1;
            r_irq      <= 1'b0;
        end else begin
            // Prescaler free-runs; register writes never disturb its phase
            r_pre <= w_tick ? '0 : r_pre + 1'b1;

            // A software write to either half wins over the tick and the
            // increment is dropped for the whole 64-bit value that cycle
            if (we_mtime_lo || we_mtime_hi) begin
                if (we_mtime_lo) r_mtime[31:0]  <= wdata;
                if (we_mtime_hi) r_mtime[63:32] <= wdata;
            end else if (w_tick) begin
                r_mtime <= r_mtime + 64'd1;
            end

            if (we_mtimecmp_lo) r_mtimecmp[31:0]  <= wdata;
            if (we_mtimecmp_hi) r_mtimecmp[63:32] <= wdata;

            // Compares the pre-edge values, so irq trails changes by a cycle
            r_irq <= (r_mtime >= r_mtimecmp);
        end
    end

    assign mtime    = r_mtime;
    assign mtimecmp = r_mtimecmp;
    assign irq      = r_irq;

endmodule : lx32_mtimer
`default_nettype wire

// File: rtl/lx32_data_mem.sv
`default_nettype none
// ============================================================================
//  Module   : lx32_data_mem
//  Purpose  : Memory-side responder for the lx32 core data port. Decodes the
//             byte address into a word RAM (bytes 0..DEPTH*4-1) and a 256-byte
//             MMIO page (machine timer, TOHOST, STATUS). Reads are
//             combinational; writes take effect at posedge clk.
//  Ports    : clk, rst_n (async, active-low)
//             bus          lx32_data_mem_if.slave (addr/wdata/we/rdata)
//             timer_irq    registered mtime >= mtimecmp
//             halt         sticky, set by a TOHOST write
//             tohost_data  last value written to TOHOST
//             bus_err      sticky unmapped/illegal write flag
//  Options  : LX32_DMEM_ALIGN_CHK_EN - misaligned writes are dropped and set
//             bus_err; otherwise addr[1:0] is ignored.
//  Revision : 1.0 - initial release
// ============================================================================
module lx32_data_mem
    import lx32_mem_pkg::*;
#(
    parameter int          DEPTH     = 1024,
    parameter int          PRESCALE  = 1,
    parameter logic [31:0] MMIO_BASE = DEFAULT_MMIO_BASE
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    lx32_data_mem_if.slave    bus,
    output logic              timer_irq,
    output logic              halt,
    output logic       [31:0] tohost_data,
    output logic              bus_err
);

    localparam int          AW          = $clog2(DEPTH);
    localparam logic [32:0] c_RAM_BYTES = 33'(DEPTH) << 2;

    logic [31:0]   r_ram [DEPTH];
    logic          r_halt;
    logic [31:0]   r_tohost;
    logic          r_bus_err;

    logic          w_is_ram;
    logic          w_is_mmio;
    logic          w_mmio_hit;
    logic          w_aligned;
    logic          w_wr;
    logic          w_wr_err;
    logic [7:0]    w_off;
    logic [AW-1:0] w_word;
    logic [31:0]   w_rdata;
    logic [31:0]   w_status;
    logic [63:0]   w_mtime;
    logic [63:0]   w_mtimecmp;
    logic          w_irq;
    logic          w_unused_ok;

    // ---------------- decode ----------------
    assign w_is_ram  = ({1'b0, bus.mem_addr} < c_RAM_BYTES);
    assign w_is_mmio = (bus.mem_addr[31:8] == MMIO_BASE[31:8]) && !w_is_ram;
    assign w_off     = {bus.mem_addr[7:2], 2'b00};
    assign w_word    = bus.mem_addr[AW+1:2];

    always_comb begin
        w_mmio_hit = 1'b0;
        case (w_off)
            MMIO_MTIME_LO, MMIO_MTIME_HI, MMIO_MTIMECMP_LO,
            MMIO_MTIMECMP_HI, MMIO_TOHOST, MMIO_STATUS: w_mmio_hit = 1'b1;
            default:                                    w_mmio_hit = 1'b0;
        endcase
    end

`ifdef LX32_DMEM_ALIGN_CHK_EN
    assign w_aligned = (bus.mem_addr[1:0] == 2'b00);
`else
    assign w_aligned = 1'b1;
`endif

    // Byte-lane bits only matter when the alignment check is built in
    assign w_unused_ok = ^bus.mem_addr[1:0];

    // A write is committed only when aligned (or alignment is ignored);
    // any other store attempt flags bus_err and leaves state untouched
    assign w_wr     = bus.mem_we && w_aligned;
    assign w_wr_err = bus.mem_we &&
                      (!w_aligned || !(w_is_ram || (w_is_mmio && w_mmio_hit)));

    // ---------------- timer ----------------
    lx32_mtimer #(
        .PRESCALE (PRESCALE)
    ) u_mtimer (
        .clk            (clk),
        .rst_n          (rst_n),
        .wdata          (bus.mem_wdata),
        .we_mtime_lo    (w_wr && w_is_mmio && (w_off == MMIO_MTIME_LO)),
        .we_mtime_hi    (w_wr && w_is_mmio && (w_off == MMIO_MTIME_HI)),
        .we_mtimecmp_lo (w_wr && w_is_mmio && (w_off == MMIO_MTIMECMP_LO)),
        .we_mtimecmp_hi (w_wr && w_is_mmio && (w_off == MMIO_MTIMECMP_HI)),
        .mtime          (w_mtime),
        .mtimecmp       (w_mtimecmp),
        .irq            (w_irq)
    );

    // ---------------- RAM ----------------
    // Gated by rst_n so a store coinciding with reset is discarded
    always_ff @(posedge clk) begin
        if (rst_n && w_wr && w_is_ram) begin
            r_ram[w_word] <= bus.mem_wdata;
        end
    end

    // ---------------- TOHOST / bus_err ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_halt    <= 1'b0;
            r_tohost  <= '0;
            r_bus_err <= 1'b0;
        end else begin
            if (w_wr && w_is_mmio && (w_off == MMIO_TOHOST)) begin
                r_tohost <= bus.mem_wdata;
                r_halt   <= 1'b1;
            end
            if (w_wr_err) begin
                r_bus_err <= 1'b1;
            end else if (w_wr && w_is_mmio && (w_off == MMIO_STATUS) &&
                         bus.mem_wdata[STATUS_BUSERR_BIT]) begin
                r_bus_err <= 1'b0;
            end
        end
    end

    // ---------------- read mux ----------------
    always_comb begin
        w_status                    = '0;
        w_status[STATUS_IRQ_BIT]    = w_irq;
        w_status[STATUS_HALT_BIT]   = r_halt;
        w_status[STATUS_BUSERR_BIT] = r_bus_err;
    end

    always_comb begin
        w_rdata = DEAD_READ;
        if (w_is_ram) begin
            w_rdata = r_ram[w_word];
        end else if (w_is_mmio) begin
            case (w_off)
                MMIO_MTIME_LO:    w_rdata = w_mtime[31:0];
                MMIO_MTIME_HI:    w_rdata = w_mtime[63:32];
                MMIO_MTIMECMP_LO: w_rdata = w_mtimecmp[31:0];
                MMIO_MTIMECMP_HI: w_rdata = w_mtimecmp[63:32];
                MMIO_TOHOST:      w_rdata = r_tohost;
                MMIO_STATUS:      w_rdata = w_status;
                default:          w_rdata = DEAD_READ;
            endcase
        end
    end

    assign bus.mem_rdata = w_rdata;
    assign timer_irq     = w_irq;
    assign halt          = r_halt;
    assign tohost_data   = r_tohost;
    assign bus_err       = r_bus_err;

endmodule : lx32_data_mem
`default_nettype wire

// File: tb/tb_lx32_data_mem.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lx32_data_mem
//  Purpose  : Self-checking bench for lx32_data_mem (PRESCALE=4). Inputs are
//             driven just after the falling edge; outputs sampled in the low
//             phase. Expected read data goes through a scoreboard queue.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_lx32_data_mem;

    localparam int          DEPTH    = 1024;
    localparam int          PRESCALE = 4;
    localparam logic [31:0] MB       = 32'h8000_0000;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        timer_irq;
    logic        halt;
    logic [31:0] tohost_data;
    logic        bus_err;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_q[$];
    logic [31:0] addr_q[$];
    logic [31:0] saved_100;

    always #5 clk = ~clk;

    lx32_data_mem_if bus ();

    lx32_data_mem #(
        .DEPTH     (DEPTH),
        .PRESCALE  (PRESCALE),
        .MMIO_BASE (MB)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .timer_irq   (timer_irq),
        .halt        (halt),
        .tohost_data (tohost_data),
        .bus_err     (bus_err)
    );

    // Combinational read: present address, let it settle, sample
    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        bus.mem_addr = a;
        #1;
        d = bus.mem_rdata;
    endtask

    // One-cycle store: call in the low phase; returns at the next falling edge
    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        bus.mem_addr  = a;
        bus.mem_wdata = d;
        bus.mem_we    = 1'b1;
        @(negedge clk);
        bus.mem_we    = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] got, e;
        @(negedge clk);
        checks++; if ({halt, timer_irq, bus_err} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b required 000", {halt, timer_irq, bus_err}); end
        checks++; if (tohost_data !== 32'h0) begin errors++; $display("FAIL reset_tohost: got %h required 0", tohost_data); end
        exp_q.push_back(32'h0);
        rd(MB + 32'h00, got); e = exp_q.pop_front();
        checks++; if (got !== e) begin errors++; $display("FAIL reset_mtime_lo: got %h required %h", got, e); end
        exp_q.push_back(32'hFFFF_FFFF);
        rd(MB + 32'h08, got); e = exp_q.pop_front();
        checks++; if (got !== e) begin errors++; $display("FAIL reset_cmp_lo: got %h required %h", got, e); end
        exp_q.push_back(32'hFFFF_FFFF);
        rd(MB + 32'h0C, got); e = exp_q.pop_front();
        checks++; if (got !== e) begin errors++; $display("FAIL reset_cmp_hi: got %h required %h", got, e); end
        exp_q.push_back(32'h0);
        rd(MB + 32'h14, got); e = exp_q.pop_front();
        checks++; if (got !== e) begin errors++; $display("FAIL reset_status: got %h required %h", got, e); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_prescaler();
        logic [31:0] got, e;
        repeat (40) @(posedge clk);
        @(negedge clk);
        exp_q.push_back(32'd10);
        exp_q.push_back(32'd0);
        rd(MB + 32'h00, got); e = exp_q.pop_front();
        checks++; if (got !== e) begin errors++; $display("FAIL presc_mtime_lo: got %0d required %0d", got, e); end
        rd(MB + 32'h04, got); e = exp_q.pop_front();
        checks++; if (got !== e) begin errors++; $display("FAIL presc_mtime_hi: got %0d required %0d", got, e); end
    endtask

    task automatic test_ram_raw();
        logic [31:0] got, e;
        @(negedge clk);
        wr(32'h40, 32'hAAAA_0000);
        wr(32'h44, 32'hBBBB_1111);
        exp_q.push_back(32'hAAAA_0000);
        exp_q.push_back(32'h1234_5678);
        exp_q.push_back(32'hBBBB_1111);
        bus.mem_addr  = 32'h40;
        bus.mem_wdata = 32'h1234_5678;
        bus.mem_we    = 1'b1;
        #1 got = bus.mem_rdata; e = exp_q.pop_front();
        checks++; if (got !== e) begin errors++; $display("FAIL ram_same_cycle: got %h required %h", got, e); end
        @(negedge clk);
        bus.mem_we = 1'b0;
        #1 got = bus.mem_rdata; e = exp_q.pop_front();
        checks++; if (got !== e) begin errors++; $display("FAIL ram_next_cycle: got %h required %h", got, e); end
        rd(32'h44, got); e = exp_q.pop_front();
        checks++; if (got !== e) begin errors++; $display("FAIL ram_neighbour: got %h required %h", got, e); end
    endtask

    task automatic test_irq();
        logic [31:0] got;
        bit          found;
        @(negedge clk);
        wr(MB + 32'h04, 32'h0);
        wr(MB + 32'h00, 32'h0);
        wr(MB + 32'h0C, 32'h0);
        wr(MB + 32'h08, 32'd5);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            rd(MB + 32'h00, got);
            if (got == 32'd5) found = 1'b1;
            else @(negedge clk);
        end
        checks++; if (!found) begin errors++; $display("FAIL irq_wait_mtime5: got timeout required mtime==5"); end
        checks++; if (timer_irq !== 1'b0) begin errors++; $display("FAIL irq_same_cycle: got %b required 0", timer_irq); end
        @(negedge clk); #1;
        checks++; if (timer_irq !== 1'b1) begin errors++; $display("FAIL irq_rise: got %b required 1", timer_irq); end
        wr(MB + 32'h0C, 32'hFFFF_FFFF);
        checks++; if (timer_irq !== 1'b1) begin errors++; $display("FAIL irq_hold: got %b required 1", timer_irq); end
        @(negedge clk); #1;
        checks++; if (timer_irq !== 1'b0) begin errors++; $display("FAIL irq_fall: got %b required 0", timer_irq); end
    endtask

    task automatic test_carry();
        logic [31:0] got, e;
        bit          found;
        @(negedge clk);
        wr(MB + 32'h04, 32'h0);
        wr(MB + 32'h00, 32'hFFFF_FFFF);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            rd(MB + 32'h00, got);
            if (got != 32'hFFFF_FFFF) found = 1'b1;
            else @(negedge clk);
        end
        checks++; if (!found) begin errors++; $display("FAIL carry_wait_tick: got timeout required tick"); end
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h1);
        e = exp_q.pop_front();
        checks++; if (got !== e) begin errors++; $display("FAIL carry_lo: got %h required %h", got, e); end
        rd(MB + 32'h04, got); e = exp_q.pop_front();
        checks++; if (got !== e) begin errors++; $display("FAIL carry_hi: got %h required %h", got, e); end
        // Tick happened on the edge before this low phase; the next is 4 edges on
        repeat (3) @(negedge clk);
        wr(MB + 32'h00, 32'd7);
        exp_q.push_back(32'd7);
        exp_q.push_back(32'h1);
        exp_q.push_back(32'd8);
        rd(MB + 32'h00, got); e = exp_q.pop_front();
        checks++; if (got !== e) begin errors++; $display("FAIL write_beats_tick: got %0d required %0d", got, e); end
        rd(MB + 32'h04, got); e = exp_q.pop_front();
        checks++; if (got !== e) begin errors++; $display("FAIL write_hi_holds: got %h required %h", got, e); end
        repeat (4) @(negedge clk);
        rd(MB + 32'h00, got); e = exp_q.pop_front();
        checks++; if (got !== e) begin errors++; $display("FAIL tick_after_write: got %0d required %0d", got, e); end
    endtask

    task automatic test_halt();
        logic [31:0] got, e;
        @(negedge clk);
        wr(MB + 32'h10, 32'h1);
        checks++; if (halt !== 1'b1 || tohost_data !== 32'h1) begin errors++; $display("FAIL tohost_first: got halt=%b data=%h required halt=1 data=1", halt, tohost_data); end
        exp_q.push_back(32'h1);
        rd(MB + 32'h10, got); e = exp_q.pop_front();
        checks++; if (got !== e) begin errors++; $display("FAIL tohost_read: got %h required %h", got, e); end
        wr(MB + 32'h10, 32'h2);
        checks++; if (halt !== 1'b1 || tohost_data !== 32'h2) begin errors++; $display("FAIL tohost_second: got halt=%b data=%h required halt=1 data=2", halt, tohost_data); end
        exp_q.push_back(32'h2);
        rd(MB + 32'h14, got); e = exp_q.pop_front();
        checks++; if (got !== e) begin errors++; $display("FAIL status_halt: got %h required %h", got, e); end
    endtask

    task automatic test_error();
        logic [31:0] got, e;
        @(negedge clk);
        wr(32'h4000_0000, 32'hCAFE_F00D);
        checks++; if (bus_err !== 1'b1) begin errors++; $display("FAIL unmapped_err: got %b required 1", bus_err); end
        exp_q.push_back(32'hDEAD_BEEF);
        exp_q.push_back(32'h1234_5678);
        exp_q.push_back(32'h6);
        rd(32'h4000_0000, got); e = exp_q.pop_front();
        checks++; if (got !== e) begin errors++; $display("FAIL unmapped_read: got %h required %h", got, e); end
        rd(32'h40, got); e = exp_q.pop_front();
        checks++; if (got !== e) begin errors++; $display("FAIL unmapped_ram_intact: got %h required %h", got, e); end
        rd(MB + 32'h14, got); e = exp_q.pop_front();
        checks++; if (got !== e) begin errors++; $display("FAIL status_err: got %h required %h", got, e); end
        wr(MB + 32'h14, 32'h4);
        checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL status_clear: got %b required 0", bus_err); end
        wr(MB + 32'h18, 32'h1);
        checks++; if (bus_err !== 1'b1) begin errors++; $display("FAIL unused_off_err: got %b required 1", bus_err); end
        exp_q.push_back(32'hDEAD_BEEF);
        rd(MB + 32'h18, got); e = exp_q.pop_front();
        checks++; if (got !== e) begin errors++; $display("FAIL unused_off_read: got %h required %h", got, e); end
        wr(MB + 32'h14, 32'h3);
        checks++; if (bus_err !== 1'b1) begin errors++; $display("FAIL status_no_clear: got %b required 1", bus_err); end
        wr(MB + 32'h14, 32'h4);
        wr(32'(DEPTH * 4), 32'h1);
        checks++; if (bus_err !== 1'b1) begin errors++; $display("FAIL ram_end_err: got %b required 1", bus_err); end
        exp_q.push_back(32'hDEAD_BEEF);
        rd(32'(DEPTH * 4), got); e = exp_q.pop_front();
        checks++; if (got !== e) begin errors++; $display("FAIL ram_end_read: got %h required %h", got, e); end
        wr(MB + 32'h14, 32'h4);
        wr(32'h42, 32'h5555_5555);
`ifdef LX32_DMEM_ALIGN_CHK_EN
        checks++; if (bus_err !== 1'b1) begin errors++; $display("FAIL misalign_err: got %b required 1", bus_err); end
        exp_q.push_back(32'h1234_5678);
`else
        checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL misalign_err: got %b required 0", bus_err); end
        exp_q.push_back(32'h5555_5555);
`endif
        rd(32'h40, got); e = exp_q.pop_front();
        checks++; if (got !== e) begin errors++; $display("FAIL misalign_ram: got %h required %h", got, e); end
        wr(MB + 32'h14, 32'h4);
    endtask

    task automatic test_back_to_back();
        logic [31:0] got, e, a, d;
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            a = (i == 7) ? 32'(DEPTH * 4 - 4) : 32'h100 + 32'(4 * i);
            d = $urandom;
            if (i == 0) saved_100 = d;
            wr(a, d);
            addr_q.push_back(a);
            exp_q.push_back(d);
        end
        while (addr_q.size() > 0) begin
            a = addr_q.pop_front();
            rd(a, got); e = exp_q.pop_front();
            checks++; if (got !== e) begin errors++; $display("FAIL b2b_ram[%h]: got %h required %h", a, got, e); end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] got, e;
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        checks++; if ({halt, bus_err, timer_irq} !== 3'b000 || tohost_data !== 32'h0) begin errors++; $display("FAIL async_reset: got halt=%b err=%b irq=%b data=%h required all 0", halt, bus_err, timer_irq, tohost_data); end
        exp_q.push_back(32'h0);
        exp_q.push_back(32'hFFFF_FFFF);
        rd(MB + 32'h00, got); e = exp_q.pop_front();
        checks++; if (got !== e) begin errors++; $display("FAIL async_reset_mtime: got %h required %h", got, e); end
        rd(MB + 32'h0C, got); e = exp_q.pop_front();
        checks++; if (got !== e) begin errors++; $display("FAIL async_reset_cmp: got %h required %h", got, e); end
        wr(MB + 32'h10, 32'h9);
        wr(32'h100, ~saved_100);
        checks++; if (halt !== 1'b0 || tohost_data !== 32'h0) begin errors++; $display("FAIL write_in_reset: got halt=%b data=%h required 0/0", halt, tohost_data); end
        exp_q.push_back(saved_100);
        rd(32'h100, got); e = exp_q.pop_front();
        checks++; if (got !== e) begin errors++; $display("FAIL ram_write_in_reset: got %h required %h", got, e); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        bus.mem_addr  = 32'h0;
        bus.mem_wdata = 32'h0;
        bus.mem_we    = 1'b0;
        test_reset();
        test_prescaler();
        test_ram_raw();
        test_irq();
        test_carry();
        test_halt();
        test_error();
        test_back_to_back();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1);
    end

endmodule : tb_lx32_data_mem
`default_nettype wire
